// File: rtl/demux_1n_stream.sv
// Registered 1:N packet demultiplexer with valid/ready on the input and on every output.
// One buffer entry per channel; the channel select is locked from a packet's first beat to its last.
module demux_1n_stream #(
  parameter int N         = 2,
  parameter int WIDTH     = 8,
  parameter int SELW      = (N > 1) ? $clog2(N) : 1,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_last,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               busy,
  output logic               err,
  output logic [7:0]         drop_cnt
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [SELW-1:0]    locked_sel_q, locked_sel_d;
  logic [N-1:0]       out_valid_q, out_valid_d;
  logic [N-1:0]       out_last_q, out_last_d;
  logic [N*WIDTH-1:0] out_data_q, out_data_d;
  logic               err_q, err_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic [SELW-1:0]    target;
  logic [N-1:0]       target_hit;
  logic               target_legal;
  logic               accept;
  logic               drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Target decode and handshake: an out-of-range target swallows the beat.
  always_comb begin
    target     = (state_q == S_LOCKED) ? locked_sel_q : in_sel;
    target_hit = '0;
    for (int k = 0; k < N; k++) begin
      target_hit[k] = (32'(target) == k);
    end
    target_legal = |target_hit;
    in_ready     = target_legal ? |(target_hit & (~out_valid_q | out_ready)) : 1'b1;
    accept       = in_valid && in_ready;
    drop         = accept && !target_legal;
  end

  always_comb begin
    state_d      = state_q;
    locked_sel_d = locked_sel_q;
    if (accept) begin
      if (in_last) begin
        state_d = S_IDLE;
      end else if (state_q == S_IDLE) begin
        state_d      = S_LOCKED;
        locked_sel_d = in_sel;
      end
    end
    err_d      = err_q | drop;
    drop_cnt_d = drop ? sat_inc8(drop_cnt_q) : drop_cnt_q;
  end

  // Per-channel buffer: a load in the same cycle as a drain keeps the entry full.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    for (int k = 0; k < N; k++) begin
      if (accept && target_hit[k]) begin
        out_valid_d[k]               = 1'b1;
        out_last_d[k]                = in_last;
        out_data_d[k*WIDTH +: WIDTH] = in_data;
      end else if (out_ready[k]) begin
        out_valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      locked_sel_q <= '0;
      out_valid_q  <= '0;
      out_last_q   <= '0;
      out_data_q   <= '0;
      err_q        <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      locked_sel_q <= locked_sel_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      err_q        <= err_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Output stage: idle channels can be forced to zero without touching the held register.
  always_comb begin
    out_data = out_data_q;
    for (int k = 0; k < N; k++) begin
      if (ZERO_IDLE && !out_valid_q[k]) begin
        out_data[k*WIDTH +: WIDTH] = '0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == S_LOCKED);
  assign err       = err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_1n_stream.sv
// Scoreboard bench for demux_1n_stream: a 4-channel zero-idle instance and a
// 3-channel hold-data instance, each checked against a per-channel queue model.
module tb_demux_1n_stream;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic             clk;
  logic             rst;
  logic [1:0][7:0]  in_data;
  logic [1:0][1:0]  in_sel;
  logic [1:0]       in_last;
  logic [1:0]       in_valid;
  logic [1:0][3:0]  ordy;

  logic [1:0]       in_ready;
  logic [1:0][31:0] od;
  logic [1:0][3:0]  ol;
  logic [1:0][3:0]  ov;
  logic [1:0]       busy;
  logic [1:0]       err;
  logic [1:0][7:0]  dcnt;

  logic        rdy0, rdy1, busy0, busy1, err0, err1;
  logic [31:0] od0;
  logic [23:0] od1;
  logic [3:0]  ol0, ov0;
  logic [2:0]  ol1, ov1;
  logic [7:0]  dc0, dc1;

  demux_1n_stream #(.N(4), .WIDTH(8), .ZERO_IDLE(1'b1)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_sel(in_sel[0]), .in_last(in_last[0]),
    .in_valid(in_valid[0]), .in_ready(rdy0),
    .out_data(od0), .out_last(ol0), .out_valid(ov0), .out_ready(ordy[0]),
    .busy(busy0), .err(err0), .drop_cnt(dc0)
  );

  demux_1n_stream #(.N(3), .WIDTH(8), .ZERO_IDLE(1'b0)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_sel(in_sel[1]), .in_last(in_last[1]),
    .in_valid(in_valid[1]), .in_ready(rdy1),
    .out_data(od1), .out_last(ol1), .out_valid(ov1), .out_ready(ordy[1][2:0]),
    .busy(busy1), .err(err1), .drop_cnt(dc1)
  );

  assign in_ready = {rdy1, rdy0};
  assign od       = {{8'h00, od1}, od0};
  assign ol       = {{1'b0, ol1}, ol0};
  assign ov       = {{1'b0, ov1}, ov0};
  assign busy     = {busy1, busy0};
  assign err      = {err1, err0};
  assign dcnt     = {dc1, dc0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // Reference model: open packet per instance, one queue per channel.
  bit         m_open  [2];
  int         m_tgt   [2];
  bit         m_err   [2];
  int         m_drops [2];
  beat_t      q       [2][4][$];
  logic [7:0] held    [2][4];

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic bit zidle(input int d);
    return (d == 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_open[d]  = 1'b0;
      m_tgt[d]   = 0;
      m_err[d]   = 1'b0;
      m_drops[d] = 0;
      for (int k = 0; k < 4; k++) begin
        q[d][k].delete();
        held[d][k] = 8'h00;
      end
    end
  endtask

  // Monitor: compares presented outputs against the queue heads, pops on transfer.
  always @(negedge clk) begin
    if (!rst && started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'(m_open[d]));
        chk($sformatf("d%0d err", d), 32'(err[d]), 32'(m_err[d]));
        chk($sformatf("d%0d drop_cnt", d), 32'(dcnt[d]), (m_drops[d] > 255) ? 32'd255 : 32'(m_drops[d]));
        for (int k = 0; k < nch(d); k++) begin
          logic [7:0] dat;
          dat = od[d][k*8 +: 8];
          chk($sformatf("d%0d ch%0d valid", d, k), 32'(ov[d][k]), 32'(q[d][k].size() > 0));
          if (ov[d][k] && q[d][k].size() > 0) begin
            chk($sformatf("d%0d ch%0d data", d, k), 32'(dat), 32'(q[d][k][0].data));
            chk($sformatf("d%0d ch%0d last", d, k), 32'(ol[d][k]), 32'(q[d][k][0].last));
            if (ordy[d][k]) begin
              held[d][k] = q[d][k][0].data;
              void'(q[d][k].pop_front());
            end
          end else if (!ov[d][k]) begin
            chk($sformatf("d%0d ch%0d idle data", d, k), 32'(dat),
                zidle(d) ? 32'd0 : 32'(held[d][k]));
          end
        end
      end
    end
  end

  // One cycle: inputs are already set after the previous rising edge; decide
  // acceptance from the model, push expected beats, then advance to the next edge.
  task automatic step();
    int tgt;
    bit legal, er;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      tgt   = m_open[d] ? m_tgt[d] : int'(in_sel[d]);
      legal = (tgt < nch(d));
      er    = legal ? (q[d][tgt].size() == 0) : 1'b1;
      chk($sformatf("d%0d in_ready", d), 32'(in_ready[d]), 32'(er));
      if (in_valid[d] && er) begin
        if (legal) begin
          q[d][tgt].push_back('{data: in_data[d], last: in_last[d]});
        end else begin
          m_err[d] = 1'b1;
          m_drops[d]++;
        end
        if (in_last[d]) begin
          m_open[d] = 1'b0;
        end else if (!m_open[d]) begin
          m_open[d] = 1'b1;
          m_tgt[d]  = tgt;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input int sel, input logic [7:0] data, input bit last);
    in_valid[d] = 1'b1;
    in_sel[d]   = 2'(sel);
    in_data[d]  = data;
    in_last[d]  = last;
  endtask

  task automatic idle(input int d);
    in_valid[d] = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst      = 1'b1;
    in_data  = '0;
    in_sel   = '0;
    in_last  = '0;
    in_valid = '0;
    ordy     = '1;
    model_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset valid", d), 32'(ov[d]), 32'd0);
      chk($sformatf("d%0d reset data", d), od[d], 32'd0);
      chk($sformatf("d%0d reset busy", d), 32'(busy[d]), 32'd0);
      chk($sformatf("d%0d reset err", d), 32'(err[d]), 32'd0);
      chk($sformatf("d%0d reset drop_cnt", d), 32'(dcnt[d]), 32'd0);
      chk($sformatf("d%0d reset in_ready", d), 32'(in_ready[d]), 32'd1);
    end
    #20;
    rst = 1'b0;
    @(posedge clk);
    #1;
    started = 1'b1;

    // 3-beat packet to ch2 with in_sel changing after the first beat.
    beat(0, 2, 8'h11, 1'b0); step();
    beat(0, 0, 8'h22, 1'b0); step();
    beat(0, 0, 8'h33, 1'b1); step();
    idle(0); steps(2);

    // Stall on ch1, then release: drain and load in the same cycle.
    ordy[0] = 4'b1101;
    beat(0, 1, 8'hA1, 1'b0); step();
    beat(0, 1, 8'hA2, 1'b1); steps(2);
    ordy[0] = 4'b1111; step();
    idle(0); steps(2);

    // Stalled ch1 must not block a single-beat packet to ch3.
    ordy[0] = 4'b1101;
    beat(0, 1, 8'hB1, 1'b1); step();
    beat(0, 3, 8'h5A, 1'b1); step();
    idle(0); steps(3);
    ordy[0] = 4'b1111; steps(2);

    // N=3: a 2-beat packet to illegal select 3 is dropped, next packet routes normally.
    beat(1, 3, 8'hE1, 1'b0); step();
    beat(1, 0, 8'hE2, 1'b1); step();
    beat(1, 0, 8'h77, 1'b1); step();
    idle(1); steps(2);
    chk("d1 err after drop", 32'(err[1]), 32'd1);
    chk("d1 drop_cnt after drop", 32'(dcnt[1]), 32'd2);

    // Drive the drop counter past saturation.
    for (int i = 0; i < 260; i++) begin
      beat(1, 3, 8'($urandom), 1'b1);
      step();
    end
    idle(1); step();
    chk("d1 drop_cnt saturated", 32'(dcnt[1]), 32'd255);

    // Randomized traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d] = ($urandom_range(0, 3) != 0);
        in_sel[d]   = 2'($urandom_range(0, 3));
        in_data[d]  = 8'($urandom);
        in_last[d]  = ($urandom_range(0, 2) == 0);
        for (int k = 0; k < 4; k++) ordy[d][k] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    // Close any open packet, then drain.
    ordy = '1;
    for (int i = 0; i < 20; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (m_open[d]) beat(d, 0, 8'hEE, 1'b1);
        else idle(d);
      end
      step();
    end
    idle(0); idle(1); steps(3);

    // Asynchronous reset in the middle of a packet to a stalled ch0.
    ordy[0] = 4'b1110;
    beat(0, 0, 8'hC1, 1'b0); step();
    beat(0, 0, 8'hC2, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d midreset valid", d), 32'(ov[d]), 32'd0);
      chk($sformatf("d%0d midreset data", d), od[d], 32'd0);
      chk($sformatf("d%0d midreset busy", d), 32'(busy[d]), 32'd0);
      chk($sformatf("d%0d midreset err", d), 32'(err[d]), 32'd0);
      chk($sformatf("d%0d midreset drop_cnt", d), 32'(dcnt[d]), 32'd0);
      chk($sformatf("d%0d midreset in_ready", d), 32'(in_ready[d]), 32'd1);
    end
    model_reset();
    idle(0); idle(1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(0, 1, 8'h3C, 1'b1); step();
    idle(0); steps(2);

    ordy = '1;
    steps(4);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < nch(d); k++) begin
        chk($sformatf("d%0d ch%0d undelivered", d, k), 32'(q[d][k].size()), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
